// File: rtl/fproc_arbiter.sv
// fproc_arbiter: shares one fproc port between N_CORES proc cores.
// Requests are latched per core and granted round-robin, one transaction at a time.
// Each response goes back to the core that asked for it as a one-cycle enable pulse.
module fproc_arbiter #(
    parameter int unsigned  N_CORES    = 4,
    parameter int unsigned  ID_WIDTH   = 8,
    parameter int unsigned  DATA_WIDTH = 32,
    localparam int unsigned CORE_W     = $clog2(N_CORES)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [N_CORES-1:0]             core_fproc_en,
    input  logic [N_CORES*ID_WIDTH-1:0]    core_fproc_id,
    output logic [N_CORES-1:0]             core_fproc_enable,
    output logic [DATA_WIDTH-1:0]          core_fproc_data,
    output logic                           fproc_req_valid,
    output logic [ID_WIDTH-1:0]            fproc_req_id,
    output logic [CORE_W-1:0]              fproc_req_core,
    input  logic                           fproc_req_ready,
    input  logic                           fproc_resp_valid,
    input  logic [DATA_WIDTH-1:0]          fproc_resp_data,
    output logic                           busy,
    output logic [1:0]                     err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [CORE_W:0]   N_CORES_X = (CORE_W+1)'(N_CORES);
    localparam logic [CORE_W-1:0] LAST_CORE = CORE_W'(N_CORES - 1);

    state_t                state;
    logic [N_CORES-1:0]    pending;
    logic [ID_WIDTH-1:0]   id_q [N_CORES];
    logic [CORE_W-1:0]     rr_ptr;
    logic [CORE_W-1:0]     gnt_core;
    logic                  err_dup;
    logic                  err_resp;

    logic                  sel_found;
    logic [CORE_W-1:0]     sel_core;
    logic [CORE_W:0]       cand_sum;
    logic [N_CORES-1:0]    done_clr_c;

    assign fproc_req_core = gnt_core;
    assign err            = {err_resp, err_dup};

    // Pending bit of the core being completed, cleared on the DONE edge
    always_comb begin
        done_clr_c = '0;
        if (state == S_DONE) begin
            done_clr_c[gnt_core] = 1'b1;
        end
    end

    // Round-robin pick: first pending core at or after rr_ptr, wrapping upward
    always_comb begin
        sel_found = 1'b0;
        sel_core  = '0;
        cand_sum  = '0;
        for (int unsigned i = 0; i < N_CORES; i++) begin
            cand_sum = {1'b0, rr_ptr} + (CORE_W+1)'(i);
            if (cand_sum >= N_CORES_X) begin
                cand_sum = cand_sum - N_CORES_X;
            end
            if (!sel_found && pending[cand_sum[CORE_W-1:0]]) begin
                sel_found = 1'b1;
                sel_core  = cand_sum[CORE_W-1:0];
            end
        end
    end

    // Request capture; a new pulse from the completing core beats its own clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            err_dup <= 1'b0;
            for (int unsigned k = 0; k < N_CORES; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < N_CORES; k++) begin
                if (core_fproc_en[k]) begin
                    if (!pending[k] || done_clr_c[k]) begin
                        pending[k] <= 1'b1;
                        id_q[k]    <= core_fproc_id[k*ID_WIDTH +: ID_WIDTH];
                    end else begin
                        err_dup <= 1'b1;
                    end
                end else if (done_clr_c[k]) begin
                    pending[k] <= 1'b0;
                end
            end
        end
    end

    // Transaction sequencer: grant, hand off to fproc, collect response, notify core
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            rr_ptr            <= '0;
            gnt_core          <= '0;
            fproc_req_valid   <= 1'b0;
            fproc_req_id      <= '0;
            core_fproc_enable <= '0;
            core_fproc_data   <= '0;
            busy              <= 1'b0;
            err_resp          <= 1'b0;
        end else begin
            core_fproc_enable <= '0;
            if (fproc_resp_valid && (state != S_WAIT)) begin
                err_resp <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (sel_found) begin
                        gnt_core        <= sel_core;
                        fproc_req_id    <= id_q[sel_core];
                        fproc_req_valid <= 1'b1;
                        busy            <= 1'b1;
                        state           <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (fproc_req_ready) begin
                        fproc_req_valid <= 1'b0;
                        state           <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fproc_resp_valid) begin
                        core_fproc_data             <= fproc_resp_data;
                        core_fproc_enable[gnt_core] <= 1'b1;
                        state                       <= S_DONE;
                    end
                end
                S_DONE: begin
                    rr_ptr <= (gnt_core == LAST_CORE) ? '0 : gnt_core + CORE_W'(1);
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    fproc_req_valid <= 1'b0;
                    busy            <= 1'b0;
                    state           <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fproc_arbiter.sv
// tb_fproc_arbiter: directed and randomized checks of fproc_arbiter against a
// transaction-level model (pending flags, ids, round-robin pointer, error flags).
module tb_fproc_arbiter;

    localparam int unsigned N   = 4;
    localparam int unsigned IDW = 8;
    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic [N-1:0]       core_fproc_en;
    logic [N*IDW-1:0]   core_fproc_id;
    logic [N-1:0]       core_fproc_enable;
    logic [DW-1:0]      core_fproc_data;
    logic               fproc_req_valid;
    logic [IDW-1:0]     fproc_req_id;
    logic [CW-1:0]      fproc_req_core;
    logic               fproc_req_ready;
    logic               fproc_resp_valid;
    logic [DW-1:0]      fproc_resp_data;
    logic               busy;
    logic [1:0]         err;

    always #5 clk = ~clk;

    fproc_arbiter #(.N_CORES(N), .ID_WIDTH(IDW), .DATA_WIDTH(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .core_fproc_en     (core_fproc_en),
        .core_fproc_id     (core_fproc_id),
        .core_fproc_enable (core_fproc_enable),
        .core_fproc_data   (core_fproc_data),
        .fproc_req_valid   (fproc_req_valid),
        .fproc_req_id      (fproc_req_id),
        .fproc_req_core    (fproc_req_core),
        .fproc_req_ready   (fproc_req_ready),
        .fproc_resp_valid  (fproc_resp_valid),
        .fproc_resp_data   (fproc_resp_data),
        .busy              (busy),
        .err               (err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic           m_pend [N];
    logic [IDW-1:0] m_id   [N];
    int             m_rr;
    logic [1:0]     m_err;

    initial begin
        #500000;
        $display("FAIL watchdog observed=hang expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_pend[k] = 1'b0;
            m_id[k]   = '0;
        end
        m_rr  = 0;
        m_err = 2'b00;
    endtask

    function automatic logic [N-1:0] pend_mask();
        logic [N-1:0] m;
        m = '0;
        for (int k = 0; k < N; k++) m[k] = m_pend[k];
        return m;
    endfunction

    function automatic int model_next();
        for (int i = 0; i < N; i++) begin
            if (m_pend[(m_rr + i) % N]) return (m_rr + i) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        model_reset();
    endtask

    task automatic pulse(input logic [N-1:0] mask, input logic [N*IDW-1:0] ids);
        core_fproc_en = mask;
        core_fproc_id = ids;
        for (int k = 0; k < N; k++) begin
            if (mask[k]) begin
                if (m_pend[k]) begin
                    m_err[0] = 1'b1;
                end else begin
                    m_pend[k] = 1'b1;
                    m_id[k]   = ids[k*IDW +: IDW];
                end
            end
        end
        tick();
        core_fproc_en = '0;
    endtask

    // One full transaction: grant check, backpressure, optional injection, response, completion
    task automatic serve(input int rdly, input int wdly, input logic [DW-1:0] data,
                         input logic [N-1:0] inj, input bit done_en,
                         input logic [IDW-1:0] done_id, output int granted);
        int cnt;
        int exp;
        logic [IDW-1:0] eid;
        cnt = 0;
        granted = -1;
        while (!fproc_req_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        check("req_seen", fproc_req_valid, 1);
        if (!fproc_req_valid) return;
        exp = model_next();
        if (exp < 0) begin
            check("spurious_req", fproc_req_valid, 0);
            return;
        end
        granted = exp;
        eid = m_id[exp];
        check("req_core", fproc_req_core, exp);
        check("req_id", fproc_req_id, eid);
        for (int d = 0; d < rdly; d++) begin
            tick();
            check("bp_valid", fproc_req_valid, 1);
            check("bp_id", fproc_req_id, eid);
            check("bp_core", fproc_req_core, exp);
        end
        fproc_req_ready = 1'b1;
        tick();
        fproc_req_ready = 1'b0;
        check("wait_valid_low", fproc_req_valid, 0);
        check("wait_busy", busy, 1);
        if (inj != '0) pulse(inj, (N*IDW)'($urandom()));
        repeat (wdly) tick();
        check("wait_no_enable", core_fproc_enable, 0);
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = data;
        tick();
        fproc_resp_valid = 1'b0;
        check("done_enable", core_fproc_enable, 64'(1) << exp);
        check("done_data", core_fproc_data, data);
        m_pend[exp] = 1'b0;
        m_rr = (exp + 1) % N;
        if (done_en) begin
            core_fproc_en[exp]             = 1'b1;
            core_fproc_id[exp*IDW +: IDW]  = done_id;
            m_pend[exp] = 1'b1;
            m_id[exp]   = done_id;
        end
        tick();
        core_fproc_en = '0;
        check("enable_one_cycle", core_fproc_enable, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        int g;
        int cnt;
        bit seen;
        reset            = 1'b0;
        core_fproc_en    = '0;
        core_fproc_id    = '0;
        fproc_req_ready  = 1'b0;
        fproc_resp_valid = 1'b0;
        fproc_resp_data  = '0;
        model_reset();
        tick();
        tick();

        // Reset values
        check("rst_enable", core_fproc_enable, 0);
        check("rst_data", core_fproc_data, 0);
        check("rst_valid", fproc_req_valid, 0);
        check("rst_id", fproc_req_id, 0);
        check("rst_core", fproc_req_core, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        reset = 1'b1;
        tick();

        // Single request, minimum latency
        pulse(4'b0100, {8'h00, 8'h5A, 8'h00, 8'h00});
        check("t1_no_valid", fproc_req_valid, 0);
        tick();
        check("t2_valid", fproc_req_valid, 1);
        check("t2_id", fproc_req_id, 8'h5A);
        check("t2_core", fproc_req_core, 2);
        serve(0, 3, 32'hDEADBEEF, '0, 1'b0, '0, g);
        check("single_core", g, 2);

        // Round-robin from a fresh pointer
        do_reset();
        pulse(4'b1111, {8'h44, 8'h33, 8'h22, 8'h11});
        for (int i = 0; i < N; i++) begin
            serve(0, 0, $urandom(), '0, 1'b0, '0, g);
            check("rr_order", g, i);
        end
        pulse(4'b1001, {8'hA3, 8'h00, 8'h00, 8'hA0});
        serve(0, 0, $urandom(), '0, 1'b0, '0, g);
        check("rr_wrap_first", g, 0);
        serve(0, 0, $urandom(), '0, 1'b0, '0, g);
        check("rr_wrap_second", g, 3);

        // Backpressure: ten cycles without ready
        pulse(4'b0010, {8'h00, 8'h00, 8'h3C, 8'h00});
        serve(10, 0, 32'h0BAD_F00D, '0, 1'b0, '0, g);
        check("bp_core_served", g, 1);

        // New request from the completing core in its DONE cycle
        pulse(4'b0100, {8'h00, 8'h10, 8'h00, 8'h00});
        serve(0, 1, 32'h1234_5678, '0, 1'b1, 8'h77, g);
        serve(0, 0, 32'h8765_4321, '0, 1'b0, '0, g);
        check("done_regrant_core", g, 2);
        check("done_no_err", err, 2'b00);

        // Response strobe while idle
        fproc_resp_valid = 1'b1;
        fproc_resp_data  = 32'hCAFE_0001;
        tick();
        fproc_resp_valid = 1'b0;
        m_err[1] = 1'b1;
        check("stray_no_enable", core_fproc_enable, 0);
        check("stray_err", err, m_err);
        tick();
        check("stray_no_enable2", core_fproc_enable, 0);
        check("stray_idle", busy, 0);

        // Duplicate request keeps the original id
        pulse(4'b0010, {8'h00, 8'h00, 8'h11, 8'h00});
        pulse(4'b0010, {8'h00, 8'h00, 8'h22, 8'h00});
        serve(0, 0, $urandom(), '0, 1'b0, '0, g);
        check("dup_err", err, m_err);
        check("dup_err_value", err, 2'b11);

        // Reset in WAIT with three cores pending
        pulse(4'b0111, {8'h00, 8'hC2, 8'hC1, 8'hC0});
        cnt = 0;
        while (!fproc_req_valid && cnt < 50) begin
            tick();
            cnt++;
        end
        check("mid_req_seen", fproc_req_valid, 1);
        fproc_req_ready = 1'b1;
        tick();
        fproc_req_ready = 1'b0;
        check("mid_in_wait", busy, 1);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_valid", fproc_req_valid, 0);
        check("mid_rst_enable", core_fproc_enable, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_pending", dut.pending, 0);
        model_reset();
        tick();
        reset = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick();
            if (fproc_req_valid || core_fproc_enable != '0) seen = 1'b1;
        end
        check("post_rst_quiet", seen, 0);

        // Randomized traffic against the model
        for (int it = 0; it < 30; it++) begin
            if (pend_mask() == '0) begin
                pulse(N'($urandom_range(1, (1 << N) - 1)), (N*IDW)'($urandom()));
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom(),
                  N'($urandom()) & ~pend_mask(), 1'b0, '0, g);
        end
        cnt = 0;
        while (pend_mask() != '0 && cnt < 20) begin
            serve($urandom_range(0, 2), $urandom_range(0, 2), $urandom(), '0, 1'b0, '0, g);
            cnt++;
        end
        check("rand_drained", pend_mask(), 0);
        check("rand_err", err, m_err);
        check("rand_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fproc_arbiter.md
# fproc_arbiter

Shares one function-processor (fproc) port between `N_CORES` proc cores. Each core raises a one-cycle `fproc_en_out` pulse with an `fproc_id` and then stalls in its ctrl unit until `fproc_enable` returns. This block latches each request, grants the shared fproc port round-robin with a single transaction outstanding, and routes the response back to the requesting core as a one-cycle `fproc_enable` pulse with result data. It sits between the proc array and the fproc/measurement block.

## Interface
- `N_CORES`, 4: number of requesting cores, 2..16.
- `ID_WIDTH`, 8: fproc id width; matches the core `SYNC_BARRIER_WIDTH`.
- `DATA_WIDTH`, 32: response data width.
- `CORE_W`, `$clog2(N_CORES)`: core index width (localparam).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `core_fproc_en`  in  N_CORES  per-core request pulse (the core's `fproc_en_out`).
- `core_fproc_id`  in  N_CORES*ID_WIDTH  per-core id; core k occupies bits [k*ID_WIDTH +: ID_WIDTH].
- `core_fproc_enable`  out  N_CORES  one-hot, one-cycle completion pulse to the core's `fproc_enable`.
- `core_fproc_data`  out  DATA_WIDTH  result; valid only in the cycle `core_fproc_enable` is high.
- `fproc_req_valid`  out  1  request to the fproc block.
- `fproc_req_id`  out  ID_WIDTH  id of the granted request.
- `fproc_req_core`  out  CORE_W  index of the granted core.
- `fproc_req_ready`  in  1  fproc accepts the request.
- `fproc_resp_valid`  in  1  one-cycle response strobe.
- `fproc_resp_data`  in  DATA_WIDTH  response payload.
- `busy`  out  1  high when the state is not IDLE.
- `err`  out  2  sticky. Bit0 is a duplicate request (en while pending). Bit1 is an unexpected response.

## Operation
- Per core k there is a `pending[k]` flag and a captured `id[k]`.
  - `core_fproc_en[k]` sets `pending[k]` and captures the id on the same edge.
  - If `pending[k]` is already 1, the stored id is kept and `err[0]` is set.
- FSM states are IDLE, REQ, WAIT and DONE.
- **IDLE:** if any `pending` bit is set, grant the first set bit at or after `rr_ptr`, searching upward with wrap. Register the grant into `gnt_core` and `fproc_req_id`, then go to REQ.
- **REQ:** `fproc_req_valid` = 1, with id and core held stable. When `fproc_req_ready` = 1, go to WAIT.
- **WAIT:** when `fproc_resp_valid` = 1, register `fproc_resp_data` into `core_fproc_data`, then go to DONE.
- **DONE:** for one cycle, `core_fproc_enable[gnt_core]` = 1.
  - Clear `pending[gnt_core]`.
  - Set `rr_ptr` = (`gnt_core` + 1) mod N_CORES.
  - Go to IDLE.
- `fproc_resp_valid` in any state other than WAIT is ignored and sets `err[1]`.
- If the completing core pulses `core_fproc_en` in the DONE cycle, the set wins over the clear: it stays pending with the new id, and `err[0]` is not set.
- `err` bits clear only on reset.

## Timing
- **Reset values:** all outputs 0, all `pending` bits 0, `rr_ptr` = 0, state IDLE. Reset is asynchronous, so it aborts any in-flight transaction with no completion pulse.
- **Minimum latency**, with the request pulse in cycle t into an idle arbiter:
  - `pending` is set from t+1.
  - `fproc_req_valid` rises in t+2.
  - With ready already high, WAIT holds from t+3.
  - A response in WAIT cycle w gives `core_fproc_enable` in w+1.
- `fproc_req_valid` never drops before ready is seen. Id and core do not change while valid is high.
- Completion rate is at most one per 4 cycles (IDLE, REQ, WAIT, DONE). No requests are lost under continuous load.
- Round-robin fairness: with all cores pending, every core is served once in each window of N_CORES grants.

## Test plan
- **Single request:** core 2 pulses en with id 0x5A, ready tied to 1, response data 0xDEADBEEF 3 cycles after WAIT.
  - Expect `fproc_req_id`=0x5A and `fproc_req_core`=2 at t+2.
  - Expect `core_fproc_enable`=4'b0100 for exactly one cycle with data 0xDEADBEEF.
- **Round-robin:** all 4 cores request in the same cycle, responses immediate. Grant order is 0,1,2,3. Then core 0 and core 3 request together again, and the grant order is 0 then 3 (`rr_ptr`=0 after the wrap).
- **Backpressure:** ready held low for 10 cycles. `fproc_req_valid`, id and core stay stable for all 10 cycles; the transition to WAIT happens on the first ready cycle.
- **Errors and DONE overlap:**
  - A response strobe while IDLE sets `err[1]`, and no enable pulse is generated.
  - A second en from core 1 while pending sets `err[0]` and the original id is kept.
  - A new en from the completing core during DONE is re-granted later with the new id, and `err[0]` stays 0.
- **Reset mid-operation:** assert reset in WAIT with 3 cores pending. All outputs, `pending` and `busy` go to 0 immediately. After release, with no new requests, there is no `fproc_req_valid`.
